i2c_reg_seq: RTL and testbench
==============================

I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter I2C_FREQ, default 100_000, SCL frequency in Hz; BIT_CYC = CLK_FREQ/I2C_FREQ.
REQ-003 Parameter MSB_FIRST, default 1, driven constantly on msb_lsb.
REQ-004 Parameter TIMEOUT_BITS, default 12, maximum wait for each end_trans edge, in units of BIT_CYC.
REQ-005 Clock and reset: one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 arstn  in  1  synchronous active-low reset.
REQ-008 cmd_valid  in  1  command request.
REQ-009 cmd_ready  out  1  high only in IDLE.
REQ-010 cmd_rw  in  1  1 = read, 0 = write.
REQ-011 cmd_slave  in  7  7-bit slave address.
REQ-012 cmd_len  in  3  data byte count minus 1 (1..8 bytes).
REQ-013 wr_data  in  8  write byte.
REQ-014 wr_valid  in  1  write byte offered.
REQ-015 wr_ready  out  1  high only in LOAD.
REQ-016 rd_data  out  8  received byte.
REQ-017 rd_valid  out  1  one-cycle pulse per received byte.
REQ-018 done  out  1  one-cycle pulse at command end.
REQ-019 err  out  1  valid with done: 1 = timeout/NACK.
REQ-020 busy  out  1  high whenever state is not IDLE.
REQ-021 ena_i2c  out  1  byte-engine enable.
REQ-022 adrr_r_w  out  8  {cmd_slave, cmd_rw}, registered.
REQ-023 byte_2_send  out  8  current write byte.
REQ-024 msb_lsb  out  1  bit order.
REQ-025 end_trans  in  1  engine ack phase, multi-cycle level.
REQ-026 byte_received  in  8  engine receive byte.

Function
REQ-027 FSM states SHALL be IDLE, LOAD, RUN, GUARD.
- IDLE -> LOAD on cmd_valid with cmd_rw=0.
- IDLE -> RUN on cmd_valid with cmd_rw=1.
- Command fields SHALL be latched on that cycle.
REQ-028 LOAD SHALL accept cmd_len+1 bytes into an 8-entry buffer, one per wr_valid&wr_ready cycle, then enter RUN on the cycle after the last byte is accepted.
REQ-029 RUN SHALL assert ena_i2c and detect end_trans rising edges (registered previous value) with edge counter k starting at 0.
REQ-030 Edge k=0 (address ack) SHALL present buffer entry 0 on byte_2_send for writes; byte_2_send SHALL be held stable until the next edge.
REQ-031 Edge k in 1..cmd_len+1, reads: capture byte_received into rd_data and pulse rd_valid on the cycle after the edge.
REQ-032 Edge k in 1..cmd_len, writes: advance byte_2_send to entry k.
REQ-033 Edge k = cmd_len+1 SHALL deassert ena_i2c on the cycle after the edge and enter GUARD with err=0.
REQ-034 In RUN, a counter SHALL reset on every edge; reaching TIMEOUT_BITS*BIT_CYC SHALL drop ena_i2c and enter GUARD with err=1. This covers slave NACK, since the engine then never re-enters ack.
REQ-035 GUARD SHALL hold ena_i2c=0 for 2*BIT_CYC cycles (stop completion), then pulse done with err and return to IDLE.
REQ-036 Commands arriving while busy SHALL be ignored (cmd_ready=0); wr_valid outside LOAD SHALL be ignored.
REQ-037 An end_trans level held high across multiple cycles SHALL count as exactly one edge.
REQ-038 cmd_len=7 SHALL transfer exactly 8 bytes; counter widths SHALL hold cmd_len+1 without overflow.

Reset
REQ-039 On arstn=0 at a clk edge, the block SHALL enter IDLE with:
- ena_i2c=0, rd_valid=0, done=0, err=0.
- rd_data=0, byte_2_send=0, adrr_r_w=0.
- buffer write pointer and edge counter zeroed.
REQ-040 Reset mid-transfer SHALL drop ena_i2c on the next cycle with no done pulse.

Structure
REQ-041 A package i2c_pkg SHALL hold the FSM state typedef and BIT_CYC/timeout width helpers.
REQ-042 The 8x8 write buffer SHALL be a sub-module i2c_byte_buf, with synchronous write and combinational read by index.

Verification
REQ-043 Write: slave 0x50, cmd_len=1, bytes 0xA5, 0x3C, ACKing slave model.
- adrr_r_w=0xA0; bus shows 0xA5 then 0x3C.
- done=1, err=0.
REQ-044 Read: slave 0x68, cmd_len=2, slave returns 0x11, 0x22, 0x33.
- Three rd_valid pulses in that order.
- done=1, err=0.
REQ-045 NACK on address 0x3F: no end_trans edge occurs; done with err=1 after 12*BIT_CYC+2*BIT_CYC cycles.
REQ-046 cmd_len=7 write: exactly 8 bytes accepted, then wr_ready=0, then 8 bytes on bus.
REQ-047 arstn pulsed during the 2nd read byte: all outputs at reset values the next cycle, no done; a following write command completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and sizing helpers for the I2C register-sequence controller.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        GUARD = 2'd3
    } state_t;

    function automatic int bit_cyc(input int clk_freq, input int i2c_freq);
        return clk_freq / i2c_freq;
    endfunction

    // Smallest width able to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/i2c_byte_buf.sv
// 8x8 write-byte buffer: synchronous write port, combinational read port.
module i2c_byte_buf (
    input  logic       clk,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [8];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_reg_seq.sv
// Command sequencer driving an external I2C byte engine: buffers write bytes,
// tracks ack-phase edges from the engine, captures read bytes, times out on NACK.
module i2c_reg_seq
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int I2C_FREQ     = 100_000,
    parameter int MSB_FIRST    = 1,
    parameter int TIMEOUT_BITS = 12
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_slave,
    input  logic [2:0] cmd_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       err,
    output logic       busy,
    output logic       ena_i2c,
    output logic [7:0] adrr_r_w,
    output logic [7:0] byte_2_send,
    output logic       msb_lsb,
    input  logic       end_trans,
    input  logic [7:0] byte_received
);

    localparam int BIT_CYC = bit_cyc(CLK_FREQ, I2C_FREQ);
    localparam int TO_MAX  = TIMEOUT_BITS * BIT_CYC;
    localparam int GD_MAX  = 2 * BIT_CYC;
    localparam int TW      = cnt_width(TO_MAX);
    localparam int GW      = cnt_width(GD_MAX);

    state_t        state_q, state_d;
    logic          rw_q, rw_d;
    logic [2:0]    len_q, len_d;
    logic [7:0]    adrr_q, adrr_d;
    logic [3:0]    wptr_q, wptr_d;
    logic [3:0]    k_q, k_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0] gd_cnt_q, gd_cnt_d;
    logic          end_prev_q, end_prev_d;
    logic [7:0]    byte_tx_q, byte_tx_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          err_flag_q, err_flag_d;

    logic          buf_we;
    logic [7:0]    buf_rdata;
    logic          ack_edge;

    i2c_byte_buf u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wptr_q[2:0]),
        .wdata (wr_data),
        .raddr (k_q[2:0]),
        .rdata (buf_rdata)
    );

    // A held-high end_trans level yields a single edge.
    assign ack_edge = end_trans & ~end_prev_q;

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        len_d      = len_q;
        adrr_d     = adrr_q;
        wptr_d     = wptr_q;
        k_d        = k_q;
        to_cnt_d   = to_cnt_q;
        gd_cnt_d   = gd_cnt_q;
        end_prev_d = end_trans;
        byte_tx_d  = byte_tx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_flag_d = err_flag_q;
        buf_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rw_d       = cmd_rw;
                    len_d      = cmd_len;
                    adrr_d     = {cmd_slave, cmd_rw};
                    wptr_d     = 4'd0;
                    k_d        = 4'd0;
                    to_cnt_d   = '0;
                    err_flag_d = 1'b0;
                    state_d    = cmd_rw ? RUN : LOAD;
                end
            end
            LOAD: begin
                if (wr_valid) begin
                    buf_we = 1'b1;
                    wptr_d = wptr_q + 4'd1;
                    if (wptr_q == {1'b0, len_q}) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (ack_edge) begin
                    to_cnt_d = '0;
                    k_d      = k_q + 4'd1;
                    // Edge k acks the previous byte; present byte k for the next write slot.
                    if (!rw_q && (k_q <= {1'b0, len_q})) begin
                        byte_tx_d = buf_rdata;
                    end
                    if (rw_q && (k_q != 4'd0)) begin
                        rd_data_d  = byte_received;
                        rd_valid_d = 1'b1;
                    end
                    if (k_q == ({1'b0, len_q} + 4'd1)) begin
                        state_d    = GUARD;
                        gd_cnt_d   = '0;
                        err_flag_d = 1'b0;
                    end
                end else if (to_cnt_q == TW'(TO_MAX - 1)) begin
                    state_d    = GUARD;
                    gd_cnt_d   = '0;
                    err_flag_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            GUARD: begin
                if (gd_cnt_q == GW'(GD_MAX - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = err_flag_q;
                end else begin
                    gd_cnt_d = gd_cnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            len_q      <= 3'd0;
            adrr_q     <= 8'd0;
            wptr_q     <= 4'd0;
            k_q        <= 4'd0;
            to_cnt_q   <= '0;
            gd_cnt_q   <= '0;
            end_prev_q <= 1'b0;
            byte_tx_q  <= 8'd0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            len_q      <= len_d;
            adrr_q     <= adrr_d;
            wptr_q     <= wptr_d;
            k_q        <= k_d;
            to_cnt_q   <= to_cnt_d;
            gd_cnt_q   <= gd_cnt_d;
            end_prev_q <= end_prev_d;
            byte_tx_q  <= byte_tx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign wr_ready    = (state_q == LOAD);
    assign busy        = (state_q != IDLE);
    assign ena_i2c     = (state_q == RUN);
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign done        = done_q;
    assign err         = err_q;
    assign adrr_r_w    = adrr_q;
    assign byte_2_send = byte_tx_q;
    assign msb_lsb     = (MSB_FIRST != 0);

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq with an ack-phase engine model (BIT_CYC = 10).
module tb_i2c_reg_seq;

    localparam int BIT = 10;

    logic       clk = 1'b0;
    logic       arstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_slave;
    logic [2:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       err;
    logic       busy;
    logic       ena_i2c;
    logic [7:0] adrr_r_w;
    logic [7:0] byte_2_send;
    logic       msb_lsb;
    logic       end_trans;
    logic [7:0] byte_received;

    int n_checks = 0;
    int n_errors = 0;

    i2c_reg_seq #(
        .CLK_FREQ     (1000),
        .I2C_FREQ     (100),
        .MSB_FIRST    (1),
        .TIMEOUT_BITS (12)
    ) dut (
        .clk           (clk),
        .arstn         (arstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rw        (cmd_rw),
        .cmd_slave     (cmd_slave),
        .cmd_len       (cmd_len),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .ena_i2c       (ena_i2c),
        .adrr_r_w      (adrr_r_w),
        .byte_2_send   (byte_2_send),
        .msb_lsb       (msb_lsb),
        .end_trans     (end_trans),
        .byte_received (byte_received)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic rw, input logic [6:0] sl, input logic [2:0] ln);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_slave = sl;
        cmd_len   = ln;
        step();
        cmd_valid = 1'b0;
    endtask

    // Raise end_trans; the sample after this is the cycle following the edge.
    task automatic edge_hi();
        end_trans = 1'b1;
        step();
    endtask

    // Hold the level one more cycle, then drop it and leave a short gap.
    task automatic hold_drop();
        step();
        end_trans = 1'b0;
        step();
        step();
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int n;
        n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, err, exp_err);
        step();
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic run_write(input string tag, input logic [6:0] sl, input logic [2:0] ln,
                             input logic [7:0] b [8]);
        send_cmd(1'b0, sl, ln);
        chk({tag, "_adr"}, adrr_r_w, {sl, 1'b0});
        for (int i = 0; i <= int'(ln); i++) begin
            wr_data  = b[i];
            wr_valid = 1'b1;
            chk({tag, "_wr_ready"}, wr_ready, 1);
            step();
        end
        wr_valid = 1'b0;
        chk({tag, "_wr_ready_off"}, wr_ready, 0);
        chk({tag, "_ena_run"}, ena_i2c, 1);
        for (int k = 0; k <= int'(ln); k++) begin
            edge_hi();
            chk({tag, "_byte"}, byte_2_send, b[k]);
            hold_drop();
            chk({tag, "_byte_hold"}, byte_2_send, b[k]);
        end
        edge_hi();
        chk({tag, "_ena_off"}, ena_i2c, 0);
        hold_drop();
        wait_done(tag, 1'b0);
    endtask

    logic [7:0] wb [8];
    logic [7:0] rb [3];
    int         cyc;
    int         dcount;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arstn         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_rw        = 1'b0;
        cmd_slave     = 7'd0;
        cmd_len       = 3'd0;
        wr_data       = 8'd0;
        wr_valid      = 1'b0;
        end_trans     = 1'b0;
        byte_received = 8'd0;
        step();
        step();
        chk("rst_ena", ena_i2c, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_byte", byte_2_send, 0);
        chk("rst_adr", adrr_r_w, 0);
        chk("rst_busy", busy, 0);
        chk("rst_msb_lsb", msb_lsb, 1);
        arstn = 1'b1;
        step();

        // Write: slave 0x50, two bytes; a command offered mid-transfer is ignored.
        wb = '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(1'b0, 7'h50, 3'd1);
        chk("w1_adr", adrr_r_w, 8'hA0);
        chk("w1_busy", busy, 1);
        for (int i = 0; i < 2; i++) begin
            wr_data  = wb[i];
            wr_valid = 1'b1;
            chk("w1_wr_ready", wr_ready, 1);
            step();
        end
        wr_valid = 1'b0;
        chk("w1_wr_ready_off", wr_ready, 0);
        cmd_valid = 1'b1;
        cmd_rw    = 1'b1;
        cmd_slave = 7'h11;
        chk("w1_cmd_ready_busy", cmd_ready, 0);
        step();
        cmd_valid = 1'b0;
        chk("w1_cmd_ignored", adrr_r_w, 8'hA0);
        for (int k = 0; k < 2; k++) begin
            edge_hi();
            chk("w1_byte", byte_2_send, wb[k]);
            hold_drop();
            chk("w1_byte_hold", byte_2_send, wb[k]);
        end
        edge_hi();
        chk("w1_ena_off", ena_i2c, 0);
        hold_drop();
        wait_done("w1", 1'b0);

        // Read: slave 0x68, three bytes.
        rb = '{8'h11, 8'h22, 8'h33};
        send_cmd(1'b1, 7'h68, 3'd2);
        chk("r1_adr", adrr_r_w, 8'hD1);
        chk("r1_ena", ena_i2c, 1);
        edge_hi();
        chk("r1_addr_ack_no_rd", rd_valid, 0);
        hold_drop();
        for (int i = 0; i < 3; i++) begin
            byte_received = rb[i];
            edge_hi();
            chk("r1_rd_valid", rd_valid, 1);
            chk("r1_rd_data", rd_data, rb[i]);
            step();
            chk("r1_single_edge", rd_valid, 0);
            end_trans = 1'b0;
            step();
            step();
        end
        chk("r1_ena_off", ena_i2c, 0);
        wait_done("r1", 1'b0);

        // NACK on address 0x3F: no edges at all.
        send_cmd(1'b1, 7'h3F, 3'd0);
        cyc = 0;
        while (!done && cyc < 400) begin
            if (cyc == 12 * BIT - 1) chk("nack_ena_before", ena_i2c, 1);
            if (cyc == 12 * BIT) chk("nack_ena_dropped", ena_i2c, 0);
            step();
            cyc++;
        end
        chk("nack_cycles", cyc, 14 * BIT);
        chk("nack_done", done, 1);
        chk("nack_err", err, 1);
        step();

        // Eight-byte write; a ninth byte offer is refused.
        wb = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        send_cmd(1'b0, 7'h2A, 3'd7);
        for (int i = 0; i < 8; i++) begin
            wr_data  = wb[i];
            wr_valid = 1'b1;
            chk("w8_wr_ready", wr_ready, 1);
            step();
        end
        wr_data = 8'hFF;
        chk("w8_ninth_refused", wr_ready, 0);
        step();
        chk("w8_ninth_refused2", wr_ready, 0);
        wr_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            edge_hi();
            chk("w8_byte", byte_2_send, wb[k]);
            hold_drop();
        end
        chk("w8_ena_still", ena_i2c, 1);
        edge_hi();
        chk("w8_ena_off", ena_i2c, 0);
        hold_drop();
        wait_done("w8", 1'b0);

        // Reset during the second read byte, then a clean write.
        send_cmd(1'b1, 7'h68, 3'd2);
        edge_hi();
        hold_drop();
        byte_received = 8'h11;
        edge_hi();
        chk("rr_first", rd_data, 8'h11);
        hold_drop();
        byte_received = 8'h22;
        end_trans = 1'b1;
        arstn     = 1'b0;
        step();
        arstn = 1'b1;
        chk("rr_ena", ena_i2c, 0);
        chk("rr_rd_valid", rd_valid, 0);
        chk("rr_rd_data", rd_data, 0);
        chk("rr_done", done, 0);
        chk("rr_err", err, 0);
        chk("rr_adr", adrr_r_w, 0);
        chk("rr_byte", byte_2_send, 0);
        chk("rr_busy", busy, 0);
        end_trans = 1'b0;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) dcount++;
        end
        chk("rr_no_done", dcount, 0);
        wb = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_write("rw", 7'h22, 3'd0, wb);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
